mul_seq_ctrl: RTL and testbench

Sequencer for an unsigned shift-and-add multiply on the PicoComputer datapath. It owns no data: it drives the control strobes (clear, load, shift-right with serial input) of three external general-purpose registers and observes two datapath status bits. The registers are M (multiplicand), Q (multiplier, then low product) and A (accumulator, then high product). A start/busy/done handshake lets the CPU control unit issue a MUL and stall until the product sits in A:Q.

---
 rtl/mul_seq_ctrl_pkg.sv | 20 ++
 rtl/mul_seq_ctrl_if.sv | 29 ++
 rtl/mul_seq_ctrl_step_cnt.sv | 32 +++
 rtl/mul_seq_ctrl.sv | 115 +++++++++++
 tb/tb_mul_seq_ctrl.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/mul_seq_ctrl_pkg.sv
// Shared types for the shift-and-add multiply sequencer: state encoding and
// step-counter sizing.
package mul_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ADD   = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Counter must hold the value W itself, hence W+1 codes.
  function automatic int unsigned cnt_w(input int unsigned w);
    return $clog2(w + 1);
  endfunction

  localparam int unsigned CNT_W = cnt_w(16);

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// Control/status bundle between the multiply sequencer and the CPU control
// unit plus the M/Q/A register datapath.
interface mul_seq_ctrl_if;
  logic start;
  logic abort;
  logic q_lsb;
  logic a_lsb;
  logic a_carry;
  logic busy;
  logic done;
  logic m_ld;
  logic q_ld;
  logic a_cl;
  logic a_ld;
  logic a_sr;
  logic q_sr;
  logic a_ir;
  logic q_ir;

  modport master (
    output start, abort, q_lsb, a_lsb, a_carry,
    input  busy, done, m_ld, q_ld, a_cl, a_ld, a_sr, q_sr, a_ir, q_ir
  );

  modport slave (
    input  start, abort, q_lsb, a_lsb, a_carry,
    output busy, done, m_ld, q_ld, a_cl, a_ld, a_sr, q_sr, a_ir, q_ir
  );
endinterface

// File: rtl/mul_seq_ctrl_step_cnt.sv
// Loadable step down-counter for the multiply sequencer.
module mul_step_cnt #(
    parameter int unsigned WIDTH    = 5,
    parameter int unsigned LOAD_VAL = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ld_i,
    input  logic dec_i,
    input  logic clr_i,
    output logic zero_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)      cnt_d = '0;
        else if (ld_i)  cnt_d = WIDTH'(LOAD_VAL);
        else if (dec_i) cnt_d = cnt_q - WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    // Flag describes the value after this edge, so SHIFT can branch on the
    // decremented count in the same cycle.
    assign zero_o = (cnt_d == '0);

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequencer for unsigned shift-and-add multiply: drives M/Q/A register
// strobes and a start/busy/done handshake.
module mul_seq_ctrl
    import mul_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16
) (
    input logic          clk,
    input logic          rst_n,
    mul_seq_ctrl_if.slave bus
);

    localparam int unsigned CW = cnt_w(DATA_WIDTH);

    state_e state_q, state_d;
    logic   c_q, c_d;
    logic   cnt_ld, cnt_dec, cnt_clr, cnt_zero;
    logic   busy, done, m_ld, q_ld, a_cl, a_ld, a_sr, q_sr, a_ir, q_ir;

    mul_step_cnt #(
        .WIDTH    (CW),
        .LOAD_VAL (DATA_WIDTH)
    ) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .ld_i   (cnt_ld),
        .dec_i  (cnt_dec),
        .clr_i  (cnt_clr),
        .zero_o (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
        end
    end

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        cnt_ld  = 1'b0;
        cnt_dec = 1'b0;
        cnt_clr = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        m_ld    = 1'b0;
        q_ld    = 1'b0;
        a_cl    = 1'b0;
        a_ld    = 1'b0;
        a_sr    = 1'b0;
        q_sr    = 1'b0;
        a_ir    = 1'b0;
        q_ir    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.abort) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                busy    = 1'b1;
                m_ld    = 1'b1;
                q_ld    = 1'b1;
                a_cl    = 1'b1;
                cnt_ld  = 1'b1;
                c_d     = 1'b0;
                state_d = ST_ADD;
            end
            ST_ADD: begin
                busy    = 1'b1;
                a_ld    = bus.q_lsb;
                c_d     = bus.q_lsb & bus.a_carry;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                busy    = 1'b1;
                a_sr    = 1'b1;
                q_sr    = 1'b1;
                a_ir    = c_q;
                q_ir    = bus.a_lsb;
                cnt_dec = 1'b1;
                state_d = cnt_zero ? ST_DONE : ST_ADD;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = bus.start ? ST_LOAD : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides the counter update so zero flag and clear agree.
        if (bus.abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            cnt_clr = 1'b1;
            cnt_ld  = 1'b0;
            cnt_dec = 1'b0;
            c_d     = 1'b0;
        end
    end

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.m_ld = m_ld;
    assign bus.q_ld = q_ld;
    assign bus.a_cl = a_cl;
    assign bus.a_ld = a_ld;
    assign bus.a_sr = a_sr;
    assign bus.q_sr = q_sr;
    assign bus.a_ir = a_ir;
    assign bus.q_ir = q_ir;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl with behavioural M/Q/A registers and adder.
module tb_mul_seq_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mul_seq_ctrl_if bus();

    mul_seq_ctrl #(.DATA_WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [15:0] m_r, q_r, a_r, m_in, q_in;
    logic [16:0] sum;
    logic [9:0]  outs;

    assign sum         = {1'b0, a_r} + {1'b0, m_r};
    assign bus.a_carry = sum[16];
    assign bus.q_lsb   = q_r[0];
    assign bus.a_lsb   = a_r[0];
    assign outs = {bus.busy, bus.done, bus.m_ld, bus.q_ld, bus.a_cl,
                   bus.a_ld, bus.a_sr, bus.q_sr, bus.a_ir, bus.q_ir};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_r <= '0;
            q_r <= '0;
            a_r <= '0;
        end else begin
            if (bus.m_ld) m_r <= m_in;
            if (bus.q_ld)      q_r <= q_in;
            else if (bus.q_sr) q_r <= {bus.q_ir, q_r[15:1]};
            if (bus.a_cl)      a_r <= '0;
            else if (bus.a_ld) a_r <= sum[15:0];
            else if (bus.a_sr) a_r <= {bus.a_ir, a_r[15:1]};
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered with start about to be sampled (cycle 0); returns in DONE (cycle 34).
    task automatic mul_op(input string tag, input logic [15:0] mv, input logic [15:0] qv,
                          input logic [31:0] exp, input int pulse_at, input bit hold,
                          output int ald, output int air);
        int busy_n;
        int early_done;
        busy_n = 0;
        early_done = 0;
        ald = 0;
        air = 0;
        m_in = mv;
        q_in = qv;
        bus.start = 1'b1;
        tick();
        chk({tag, " load"}, {28'd0, bus.m_ld, bus.q_ld, bus.a_cl, bus.busy}, 32'hF);
        for (int cyc = 1; cyc <= 33; cyc++) begin
            bus.start = hold || (cyc == pulse_at);
            if (bus.busy) busy_n++;
            if (bus.done) early_done++;
            if (bus.a_ld) ald++;
            if (bus.a_ir) air++;
            tick();
        end
        bus.start = hold;
        chk({tag, " busy cycles"}, 32'(busy_n), 32'd33);
        chk({tag, " early done"}, 32'(early_done), 32'd0);
        chk({tag, " done/busy"}, {30'd0, bus.done, bus.busy}, 32'h2);
        chk({tag, " product"}, {a_r, q_r}, exp);
    endtask

    int ald, air;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        m_in = '0;
        q_in = '0;
        #12;
        chk("reset outs", {22'd0, outs}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("idle outs", {22'd0, outs}, 32'd0);

        mul_op("3x5", 16'd3, 16'd5, 32'h0000_000F, -1, 1'b0, ald, air);
        tick();
        chk("3x5 back to idle", {22'd0, outs}, 32'd0);

        mul_op("ffff", 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, -1, 1'b0, ald, air);
        chk("ffff a_ld count", 32'(ald), 32'd16);
        chk("ffff carry count", 32'(air), 32'd15);
        tick();

        mul_op("zero", 16'h1234, 16'h0000, 32'h0, -1, 1'b0, ald, air);
        chk("zero a_ld count", 32'(ald), 32'd0);
        tick();

        // Abort at cycle 10.
        m_in = 16'h5555;
        q_in = 16'h3333;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        chk("pre-abort busy", {31'd0, bus.busy}, 32'd1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort outs", {22'd0, outs}, 32'd0);
        tick();
        chk("abort no done", {22'd0, outs}, 32'd0);
        mul_op("post-abort", 16'h00FF, 16'h0101, 32'h0000_FFFF, -1, 1'b0, ald, air);
        tick();

        // abort with start in IDLE keeps IDLE.
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("idle abort+start", {22'd0, outs}, 32'd0);

        mul_op("pulse", 16'd3, 16'd5, 32'h0000_000F, 5, 1'b0, ald, air);
        tick();
        chk("pulse single done", {22'd0, outs}, 32'd0);

        mul_op("held1", 16'd3, 16'd5, 32'h0000_000F, -1, 1'b1, ald, air);
        mul_op("held2", 16'h1111, 16'h0003, 32'h0000_3333, -1, 1'b0, ald, air);
        tick();
        chk("held end idle", {22'd0, outs}, 32'd0);

        // Reset at cycle 20.
        m_in = 16'hAAAA;
        q_in = 16'hFFFF;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (19) tick();
        chk("pre-reset busy", {31'd0, bus.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async reset outs", {22'd0, outs}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("post-reset idle", {22'd0, outs}, 32'd0);
        mul_op("2x3", 16'd2, 16'd3, 32'h0000_0006, -1, 1'b0, ald, air);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
